// File: rtl/logs_mix_sequencer.sv
// logs_mix_sequencer
//   Plays a small programmable table of {voice mask, duration} steps into the
//   audio_mask input of the PWM mixer. Mask changes are registered only on the
//   last clock of a PWM frame, so the mixer sees each new mask from fcnt==0.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset (shared with the mixer)
//   wr_en        table write strobe (any state)
//   wr_addr      table entry to write
//   wr_mask      voice mask for that entry
//   wr_dur       duration in frames for that entry (0 plays as 1)
//   start        single-cycle start request, honoured in IDLE only
//   stop         single-cycle stop request, honoured at the next frame tick
//   loop         repeat after last_step (sampled at start)
//   last_step    final step index (sampled at start)
//   audio_mask   mask to the mixer
//   busy         high while arming or playing
//   step         index of the step currently playing
//   done         one-cycle pulse when a non-looping pattern completes
//   dbg_state    current sequencer state (0 IDLE, 1 ARM, 2 PLAY)
//
// Handshake: start/stop are level samples on the rising clock edge; there is
// no ready/acknowledge. A start seen while busy, or together with stop, is
// dropped. A stop seen while busy is remembered until the next frame tick.
module logs_mix_sequencer #(
    parameter int N     = 4,
    parameter int K     = 3,
    parameter int STEPS = 8,
    parameter int DUR_W = 8,
    parameter int AW    = $clog2(STEPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [N-1:0]     wr_mask,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic [AW-1:0]    last_step,
    output logic [N-1:0]     audio_mask,
    output logic             busy,
    output logic [AW-1:0]    step,
    output logic             done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [K-1:0]     fcnt;
    logic             frame_tick;

    logic [N-1:0]     mask_tbl [STEPS];
    logic [DUR_W-1:0] dur_tbl  [STEPS];

    logic [DUR_W-1:0] remaining, rem_d;
    logic [N-1:0]     mask_d;
    logic [AW-1:0]    step_d;
    logic             done_d;
    logic             stop_pend, pend_d;
    logic             loop_q, loop_d;
    logic [AW-1:0]    last_q, last_d;
    logic             stop_now;
    logic             load;
    logic [AW-1:0]    load_idx;

    // Free-running frame counter kept in lockstep with the mixer's counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fcnt <= '0;
        else        fcnt <= fcnt + K'(1);
    end

    assign frame_tick = &fcnt;

    // Pattern table; writes are accepted in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                mask_tbl[i] <= '0;
                dur_tbl[i]  <= '0;
            end
        end else if (wr_en) begin
            mask_tbl[wr_addr] <= wr_mask;
            dur_tbl[wr_addr]  <= wr_dur;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            audio_mask <= '0;
            remaining  <= '0;
            step       <= '0;
            done       <= 1'b0;
            stop_pend  <= 1'b0;
            loop_q     <= 1'b0;
            last_q     <= '0;
        end else begin
            state      <= state_d;
            audio_mask <= mask_d;
            remaining  <= rem_d;
            step       <= step_d;
            done       <= done_d;
            stop_pend  <= pend_d;
            loop_q     <= loop_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d  = state;
        mask_d   = audio_mask;
        rem_d    = remaining;
        step_d   = step;
        done_d   = 1'b0;
        pend_d   = stop_pend;
        loop_d   = loop_q;
        last_d   = last_q;
        load     = 1'b0;
        load_idx = '0;
        // A stop arriving on the tick clock itself counts for that tick.
        stop_now = stop_pend | stop;

        case (state)
            S_IDLE: begin
                pend_d = 1'b0;
                if (start && !stop) begin
                    loop_d  = loop;
                    last_d  = last_step;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (stop) pend_d = 1'b1;
                if (frame_tick) begin
                    if (stop_now) begin
                        state_d = S_IDLE;
                        mask_d  = '0;
                        pend_d  = 1'b0;
                    end else begin
                        load     = 1'b1;
                        load_idx = '0;
                        state_d  = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (stop) pend_d = 1'b1;
                if (frame_tick) begin
                    if (stop_now) begin
                        // Stop beats a coinciding pattern end: no done pulse.
                        state_d = S_IDLE;
                        mask_d  = '0;
                        pend_d  = 1'b0;
                    end else if (remaining > DUR_W'(1)) begin
                        rem_d = remaining - DUR_W'(1);
                    end else if (step != last_q) begin
                        load     = 1'b1;
                        load_idx = step + AW'(1);
                    end else if (loop_q) begin
                        load     = 1'b1;
                        load_idx = '0;
                    end else begin
                        state_d = S_IDLE;
                        mask_d  = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Loading snapshots the entry, so later writes to a playing step only
        // show up on its next load.
        if (load) begin
            mask_d = mask_tbl[load_idx];
            rem_d  = (dur_tbl[load_idx] == '0) ? DUR_W'(1) : dur_tbl[load_idx];
            step_d = load_idx;
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_logs_mix_sequencer.sv
module tb_logs_mix_sequencer;
  localparam int N = 4;
  localparam int K = 3;
  localparam int STEPS = 8;
  localparam int DUR_W = 8;
  localparam int AW = 3;
  localparam int FR = 8;

  // clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [N-1:0]     wr_mask = '0;
  logic [DUR_W-1:0] wr_dur = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop = 1'b0;
  logic [AW-1:0]    last_step = '0;
  logic [N-1:0]     audio_mask;
  logic             busy;
  logic [AW-1:0]    step;
  logic             done;
  logic [1:0]       dbg_state;

  logs_mix_sequencer #(.N(N), .K(K), .STEPS(STEPS), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_mask(wr_mask), .wr_dur(wr_dur), .start(start), .stop(stop),
    .loop(loop), .last_step(last_step), .audio_mask(audio_mask),
    .busy(busy), .step(step), .done(done), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: phase 0 idle, 1 waiting for first frame, 2 playing.
  int m_fcnt, m_phase, m_left, m_step, m_last;
  bit m_pend, m_loop, m_tick;
  int m_tmask [STEPS];
  int m_tdur  [STEPS];
  int exp_mask, exp_busy, exp_done;

  task automatic m_load(input int idx);
    m_step = idx;
    exp_mask = m_tmask[idx];
    m_left = (m_tdur[idx] == 0) ? 1 : m_tdur[idx];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fcnt = 0; m_phase = 0; m_left = 0; m_step = 0; m_last = 0;
      m_pend = 0; m_loop = 0;
      exp_mask = 0; exp_busy = 0; exp_done = 0;
      for (int i = 0; i < STEPS; i++) begin
        m_tmask[i] = 0;
        m_tdur[i] = 0;
      end
    end else begin
      m_tick = (m_fcnt == FR - 1);
      exp_done = 0;
      if (m_phase == 0) begin
        m_pend = 0;
        if (start && !stop) begin
          m_loop = loop;
          m_last = int'(last_step);
          m_phase = 1;
        end
      end else begin
        if (stop) m_pend = 1;
        if (m_tick) begin
          if (m_pend) begin
            m_phase = 0; exp_mask = 0; m_pend = 0;
          end else if (m_phase == 1) begin
            m_load(0); m_phase = 2;
          end else if (m_left > 1) begin
            m_left--;
          end else if (m_step != m_last) begin
            m_load(m_step + 1);
          end else if (m_loop) begin
            m_load(0);
          end else begin
            m_phase = 0; exp_mask = 0; exp_done = 1;
          end
        end
      end
      exp_busy = (m_phase != 0) ? 1 : 0;
      if (wr_en) begin
        m_tmask[wr_addr] = int'(wr_mask);
        m_tdur[wr_addr] = int'(wr_dur);
      end
      m_fcnt = (m_fcnt + 1) % FR;
    end
  end

  // Cycle compare against the model.
  always @(negedge clk) begin
    check("audio_mask", int'(audio_mask), exp_mask);
    check("busy", int'(busy), exp_busy);
    check("done", int'(done), exp_done);
    if (rst_n && m_phase == 2) check("step", int'(step), m_step);
  end

  // driver tasks
  int cap_mask [64];
  int cap_busy [64];
  int cap_done [64];
  int cap_step [64];

  task automatic write_entry(input int a, input int m, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_mask = N'(m); wr_dur = DUR_W'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_fcnt(input int v);
    bit hit;
    hit = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      @(negedge clk);
      if (m_fcnt == v) begin
        hit = 1;
        break;
      end
    end
    check("wait_fcnt_timeout", int'(hit), 1);
  endtask

  // Start at fcnt==3 then sample n cycles; optional stop and writes by index.
  task automatic play(input bit lp, input int last, input int n, input int stop_idx,
                      input int w0_idx, input int w0_a, input int w0_m, input int w0_d,
                      input int w1_idx, input int w1_a, input int w1_m, input int w1_d);
    wait_fcnt(3);
    start = 1'b1; loop = lp; last_step = AW'(last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0; wr_en = 1'b0;
      cap_mask[i] = int'(audio_mask);
      cap_busy[i] = int'(busy);
      cap_done[i] = int'(done);
      cap_step[i] = int'(step);
      if (i == stop_idx) stop = 1'b1;
      if (i == w0_idx) begin
        wr_en = 1'b1; wr_addr = AW'(w0_a); wr_mask = N'(w0_m); wr_dur = DUR_W'(w0_d);
      end
      if (i == w1_idx) begin
        wr_en = 1'b1; wr_addr = AW'(w1_a); wr_mask = N'(w1_m); wr_dur = DUR_W'(w1_d);
      end
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
  endtask

  task automatic stop_to_idle();
    bit idle;
    idle = 0;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int i = 0; i < 3 * FR; i++) begin
      if (!busy) begin
        idle = 1;
        break;
      end
      @(negedge clk);
    end
    check("stop_idle_timeout", int'(idle), 1);
  endtask

  int done_cnt, mask_or;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_audio_mask", int'(audio_mask), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_step", int'(step), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;

    // Two-step one-shot pattern.
    write_entry(0, 4'b0011, 2);
    write_entry(1, 4'b1000, 1);
    play(1'b0, 1, 34, -1, -1, 0, 0, 0, -1, 0, 0, 0);
    check("t1_busy_rise", cap_busy[0], 1);
    check("t1_arm_mask", cap_mask[3], 0);
    check("t1_s0_first", cap_mask[4], 3);
    check("t1_s0_last", cap_mask[19], 3);
    check("t1_s1_first", cap_mask[20], 8);
    check("t1_s1_last", cap_mask[27], 8);
    check("t1_end_mask", cap_mask[28], 0);
    check("t1_done_pulse", cap_done[28], 1);
    check("t1_busy_fall", cap_busy[28], 0);
    check("t1_done_after", cap_done[29], 0);
    done_cnt = 0;
    for (int i = 0; i < 34; i++) done_cnt += cap_done[i];
    check("t1_done_count", done_cnt, 1);

    // Same table, looping.
    play(1'b1, 1, 44, -1, -1, 0, 0, 0, -1, 0, 0, 0);
    check("t2_f0", cap_mask[4], 3);
    check("t2_f1", cap_mask[12], 3);
    check("t2_f2", cap_mask[20], 8);
    check("t2_f3", cap_mask[28], 3);
    check("t2_step_f2", cap_step[20], 1);
    check("t2_step_f3", cap_step[28], 0);
    done_cnt = 0;
    for (int i = 0; i < 44; i++) done_cnt += cap_done[i];
    check("t2_no_done", done_cnt, 0);
    stop_to_idle();

    // Duration 0 on a single-step pattern plays one frame.
    write_entry(0, 4'b0101, 0);
    play(1'b0, 0, 16, -1, -1, 0, 0, 0, -1, 0, 0, 0);
    check("t3_first", cap_mask[4], 5);
    check("t3_last", cap_mask[11], 5);
    check("t3_end", cap_mask[12], 0);
    check("t3_done", cap_done[12], 1);

    // Single-step loop holds without dropout across the repeat.
    play(1'b1, 0, 24, -1, -1, 0, 0, 0, -1, 0, 0, 0);
    check("t3b_repeat", cap_mask[12], 5);
    check("t3b_repeat2", cap_mask[20], 5);
    stop_to_idle();

    // Stop at fcnt==2 of the first playing frame.
    write_entry(0, 4'b0011, 2);
    write_entry(1, 4'b1000, 1);
    play(1'b1, 1, 16, 6, -1, 0, 0, 0, -1, 0, 0, 0);
    check("t4_hold", cap_mask[7], 3);
    check("t4_hold_end", cap_mask[11], 3);
    check("t4_busy_hold", cap_busy[11], 1);
    check("t4_mask_off", cap_mask[12], 0);
    check("t4_busy_off", cap_busy[12], 0);
    check("t4_no_done", cap_done[12], 0);

    // Start and stop together in IDLE is dropped.
    @(negedge clk);
    start = 1'b1; stop = 1'b1; loop = 1'b1; last_step = 3'd1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("t4_start_stop", int'(busy), 0);
    repeat (12) @(negedge clk);
    check("t4_still_idle", int'(busy), 0);

    // Writes during step 0: entry 1 visible on its load, entry 0 on next pass.
    play(1'b1, 1, 40, -1, 6, 1, 4'b0110, 1, 7, 0, 4'b1111, 2);
    check("t5_s0_old", cap_mask[12], 3);
    check("t5_s1_new", cap_mask[20], 6);
    check("t5_s0_new", cap_mask[28], 15);
    check("t5_s0_new2", cap_mask[36], 15);

    // Asynchronous reset mid-play, then an all-zero table run.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_mask", int'(audio_mask), 0);
    check("t6_async_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    play(1'b0, 2, 32, -1, -1, 0, 0, 0, -1, 0, 0, 0);
    mask_or = 0;
    for (int i = 0; i < 32; i++) mask_or |= cap_mask[i];
    check("t6_zero_mask", mask_or, 0);
    check("t6_step1", cap_step[12], 1);
    check("t6_step2", cap_step[20], 2);
    check("t6_busy_last", cap_busy[27], 1);
    check("t6_busy_fall", cap_busy[28], 0);
    check("t6_done", cap_done[28], 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/logs_mix_sequencer.md
Name: logs_mix_sequencer

Overview:
- Drives the `audio_mask` input of the PWM mixer from a small programmable pattern table.
- Each table step holds a voice-enable mask and a duration in PWM frames.
- Plays steps 0..last_step once or looping. Every mask change lands exactly on a mixer PWM frame boundary, so there are no partial-frame glitches.
- Sits between the register/control logic (table writes, start/stop) and the mixer. It shares `clk`/`rst_n` with the mixer.

Parameters:
- N, 4: number of voices; width of each mask word. Must match the mixer's N.
- K, 3: PWM counter width; frame = 2^K clocks. Must match the mixer's K.
- STEPS, 8: pattern table depth; power of 2, at least 2.
- DUR_W, 8: width of the per-step duration field, in frames.
- AW, $clog2(STEPS): step address width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- wr_en  in  1  table write strobe, one write per cycle
- wr_addr  in  AW  table entry to write
- wr_mask  in  N  mask written to the entry
- wr_dur  in  DUR_W  duration written to the entry (frames; 0 is treated as 1)
- start  in  1  single-cycle start request
- stop  in  1  single-cycle stop request
- loop  in  1  repeat the pattern after last_step; sampled at start
- last_step  in  AW  final step index; sampled at start
- audio_mask  out  N  mask to the mixer
- busy  out  1  high in ARM and PLAY
- step  out  AW  index of the step currently playing
- done  out  1  one-cycle pulse when a non-looping pattern completes

Behaviour:
- Reset (asynchronous, active-low; clock clk):
  - audio_mask=0, busy=0, step=0, done=0.
  - state=IDLE, frame counter=0, all table entries {mask=0, dur=0}, latched loop/last_step=0.
- Frame counter:
  - K-bit, free-running from reset, +1 every clock, wraps at 2^K-1 to 0. Stays in lockstep with the mixer counter.
  - frame_tick = (fcnt == 2^K-1).
  - Every audio_mask update is registered on a frame_tick clock, so the new value is visible from fcnt==0.
- Table: STEPS x (N+DUR_W) flops. A write lands at the clock edge where wr_en=1, and is allowed in any state.
- Latching rules:
  - A step's mask and duration are copied into the working registers when the step is loaded.
  - A write to the step currently playing affects only its next load.
- States:
  - IDLE: audio_mask=0, busy=0. start=1 (with stop=0) latches loop and last_step, then goes to ARM.
  - ARM: busy=1, audio_mask stays 0. On frame_tick: load entry 0 (audio_mask<=mask0, remaining<=max(dur0,1), step<=0), then go to PLAY.
  - PLAY: busy=1. On frame_tick:
    - If remaining>1: remaining-1.
    - Else if step!=last_step: load entry step+1.
    - Else if loop: load entry 0.
    - Else: audio_mask<=0, go to IDLE, done=1 on that same clock (one cycle).
- Step timing: a step of duration d occupies exactly d full frames (d*2^K clocks); d=0 occupies 1 frame.
- stop:
  - In ARM or PLAY: a pending-stop flag is set. At the next frame_tick, audio_mask<=0 and the state goes to IDLE; done stays 0.
  - stop on the frame_tick clock itself takes effect on that tick.
  - In IDLE, stop is ignored.
- start:
  - Ignored in ARM/PLAY; no restart occurs.
  - start and stop in the same cycle: stop wins, start is dropped.
- Step boundary: if the pattern end and a pending stop coincide on one tick, stop wins and done=0.
- last_step=0 plays entry 0 only; with loop=1 it repeats entry 0 indefinitely. audio_mask holds steady across the repeat, with no dropout.
- Reset asserted mid-operation: immediate return to reset values, including table contents.

Test Plan:
- K=3, write entries 0:{mask=4'b0011,dur=2}, 1:{4'b1000,dur=1}; start with loop=0, last_step=1, start asserted at fcnt=3 → busy rises next clock; audio_mask=0011 from the next fcnt==0 for 16 clocks, then 1000 for 8 clocks, then 0. done pulses for 1 cycle on the final tick clock; busy falls with it.
- Same table with loop=1 → mask sequence 0011,0011,1000,0011,... per frame indefinitely; done never asserts; step cycles 0,1,0.
- Entry 0 dur=0, last_step=0, loop=0 → mask0 held for exactly 8 clocks, then 0 and done.
- Mid-PLAY stop at fcnt=2 → mask holds to the end of that frame, is 0 from the next fcnt==0, busy falls then, done=0. A start and stop in the same IDLE cycle → remains IDLE.
- Write to entry 1 while step 0 plays → the new entry-1 values are used when step 1 loads. A write to entry 0 while step 0 plays → no change until the next loop pass.
- rst_n pulsed low mid-PLAY (asynchronously, between edges) → audio_mask=0 and busy=0 immediately; after release, a start with no writes plays an all-zero mask for 1 frame per step.
